r5p_fetch: RTL and testbench
============================

# r5p_fetch

Instruction fetch unit for the R5P core: generates sequential word fetch requests on the instruction bus, buffers returned instruction words with their PCs in a small queue, and presents them to the downstream decode stage over a valid/ready handshake. It sits directly upstream of the instruction decoder, which splits `ins_dat` into register and immediate fields. Control redirects (jump, branch, trap) arrive from execute and flush all buffered and in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] are ignored.
- `DEPTH`, default 2: instruction queue depth, power of two, at least 2.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `jmp_vld`  in  1  redirect request from execute.
- `jmp_adr`  in  32  redirect target address; bits [1:0] are ignored.
- `ifb_vld`  out  1  instruction bus request valid.
- `ifb_adr`  out  32  instruction bus request address, always word aligned.
- `ifb_rdy`  in  1  instruction bus request ready.
- `ifb_rdt`  in  32  instruction bus read data, valid exactly one cycle after a request handshake.
- `ins_vld`  out  1  instruction valid to decode.
- `ins_rdy`  in  1  decode ready.
- `ins_dat`  out  32  instruction word.
- `ins_pc`  out  32  address of `ins_dat`.

## Operation
- **Handshakes.**
  - A request handshake occurs when `ifb_vld & ifb_rdy`.
  - An instruction handshake occurs when `ins_vld & ins_rdy`.
  - Neither valid depends combinationally on its own ready.
- **State.**
  - `pc`: 32 bits, bits [1:0] held 0.
  - Queue: `DEPTH` entries of {dat, pc}, with read/write pointers of `$clog2(DEPTH)` bits and a `$clog2(DEPTH)+1`-bit occupancy counter.
  - Flag `inf` marks a response due this cycle; it carries the request PC.
  - Flag `dsc` marks that the due response is discarded.
- **Request issue.**
  - `ifb_vld = !rst & !jmp_vld & (occ + inf - pop < DEPTH)`, where `pop` is the instruction handshake this cycle.
  - `ifb_adr = pc`.
  - On a request handshake: `pc <= pc + 4` (wraps modulo 2^32), `inf <= 1`, request PC is captured. Otherwise `inf <= 0`.
- **Response capture.**
  - When `inf & !dsc & !jmp_vld`, {`ifb_rdt`, request PC} is written at the write pointer, which then increments.
  - Push and pop in the same cycle leave `occ` unchanged.
  - The credit rule guarantees a push never hits a full queue.
- **Output.**
  - `ins_vld = (occ != 0)`.
  - `ins_dat`/`ins_pc` are the head entry, forced to 0 when `ins_vld = 0`.
  - A pop increments the read pointer.
- **Redirect (`jmp_vld = 1`).**
  - `ifb_vld` is 0 in that cycle.
  - At the edge: `pc <= {jmp_adr[31:2], 2'b00}`, queue pointers and `occ` are cleared, and a response arriving that cycle is dropped.
  - `dsc` is not needed for in-flight requests because `ifb_vld = 0` during redirect, so no request is issued with the old PC. `dsc` is kept as a reserved path and is reset to 0.
  - A simultaneous instruction handshake in the redirect cycle is legal (the jumping instruction is consumed); the queue is cleared regardless.
  - The first request to the new target is issued the cycle after redirect.
- **Reset.**
  - Asserting `rst` at any time clears `occ`, pointers, `inf` and `dsc`, and sets `pc = RESET_PC & ~3`.
  - Any outstanding bus response is ignored.
  - Queue storage is not reset.

## Timing
- **Reset values:** `ifb_vld = 0` (while `rst`), `ifb_adr = RESET_PC & ~3`, `ins_vld = 0`, `ins_dat = 0`, `ins_pc = 0`.
- **Latency:** request handshake in cycle N → data on `ifb_rdt` in N+1 → `ins_vld = 1` in N+2.
- **After reset release:**
  - Cycle 0: `ifb_vld = 1`.
  - Cycle 2: first `ins_vld`, provided `ifb_rdy = 1`.
- **Throughput:** with `ifb_rdy = ins_rdy = 1` and `DEPTH >= 2`, one instruction per cycle sustained, with no bubble.
- **Redirect penalty:** `jmp_vld` in cycle J → request to target in J+1 → `ins_vld` with target in J+3.
- **Backpressure:**
  - With `ins_rdy = 0`, issue stops once `occ + inf = DEPTH`.
  - The head is stable while `ins_vld & !ins_rdy`.

## Test plan
- **Reset fetch:** `RESET_PC = 32'h8000_0000`, `ifb_rdy = ins_rdy = 1`, memory returns the address as data. Required: `ifb_adr` sequence 8000_0000, 8000_0004, …; `ins_pc`/`ins_dat` pairs match; first `ins_vld` in cycle 2; one instruction per cycle thereafter.
- **Backpressure:** hold `ins_rdy = 0` for 10 cycles. Required: exactly `DEPTH` requests issued, `ins_dat` stable, no loss or duplicate after release; PCs remain contiguous.
- **Redirect with response in flight:** `jmp_vld` with `jmp_adr = 32'h0000_1003` in the cycle a response arrives. Required: that response is never presented; the next `ifb_adr` is 0000_1000 in J+1; the next `ins_pc` is 0000_1000 in J+3.
- **Bus stall:** `ifb_rdy` toggling randomly. Required: `ifb_adr` is held while `ifb_vld & !ifb_rdy`; the instruction stream stays in PC order with no gaps.
- **Reset mid-operation:** assert `rst` with queue full and a response due. Required: immediately `ins_vld = 0`, `ins_dat = ins_pc = 0`; after release, fetch restarts at `RESET_PC`; the stale response is ignored.
- **PC wrap:** redirect to FFFF_FFFC. Required: the next request address is 0000_0000 and `ins_pc` wraps identically.

Source files
------------

// File: rtl/r5p_fetch.sv
// r5p_fetch: sequential instruction fetch with a small {dat, pc} queue
// feeding decode over a valid/ready handshake. A redirect from execute
// flushes the queue and drops any response arriving in the same cycle.
module r5p_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jmp_vld,
   input  logic [31:0] jmp_adr,
   output logic        ifb_vld,
   output logic [31:0] ifb_adr,
   input  logic        ifb_rdy,
   input  logic [31:0] ifb_rdt,
   output logic        ins_vld,
   input  logic        ins_rdy,
   output logic [31:0] ins_dat,
   output logic [31:0] ins_pc
);

   localparam int unsigned   AW         = $clog2(DEPTH);
   localparam logic [31:0]   RESET_PC_W = {RESET_PC[31:2], 2'b00};
   localparam logic [AW+1:0] DEPTH_C    = (AW+2)'(DEPTH);

   // fetch address, captured request PC, response-due and discard flags
   logic [31:0] pc_q, pc_d;
   logic [31:0] rpc_q, rpc_d;
   logic        inf_q, inf_d;
   logic        dsc_q, dsc_d;

   // queue bookkeeping
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   occ_q, occ_d;

   // queue storage (not reset)
   logic [31:0] dat_q [DEPTH];
   logic [31:0] dat_d [DEPTH];
   logic [31:0] ipc_q [DEPTH];
   logic [31:0] ipc_d [DEPTH];

   logic          pop;
   logic          push;
   logic          req;
   logic [AW+1:0] credit;

   // the two low address bits of a redirect target carry no information
   logic unused_jmp_lsb;
   assign unused_jmp_lsb = ^jmp_adr[1:0];

   // decode-side outputs come straight from occupancy and the head entry
   always_comb begin
      ins_vld = (occ_q != '0);
      ins_dat = '0;
      ins_pc  = '0;
      if (ins_vld) begin
         ins_dat = dat_q[rd_ptr_q];
         ins_pc  = ipc_q[rd_ptr_q];
      end
   end

   // issue credit counts queued entries plus the one in flight, minus the
   // entry leaving this cycle, so a response always finds a free slot
   always_comb begin
      pop     = ins_vld & ins_rdy;
      credit  = {1'b0, occ_q} + (AW+2)'(inf_q) - (AW+2)'(pop);
      ifb_vld = !rst & !jmp_vld & (credit < DEPTH_C);
      ifb_adr = pc_q;
      req     = ifb_vld & ifb_rdy;
      push    = inf_q & !dsc_q & !jmp_vld;
   end

   // next-state: fetch PC, in-flight tracking and queue pointers
   always_comb begin
      pc_d     = pc_q;
      rpc_d    = rpc_q;
      inf_d    = req;
      dsc_d    = 1'b0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (jmp_vld) begin
         pc_d     = {jmp_adr[31:2], 2'b00};
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (req) begin
            pc_d  = pc_q + 32'd4;
            rpc_d = pc_q;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   // next-state: queue storage written at the write pointer on a push
   always_comb begin
      dat_d = dat_q;
      ipc_d = ipc_q;
      if (push) begin
         dat_d[wr_ptr_q] = ifb_rdt;
         ipc_d[wr_ptr_q] = rpc_q;
      end
   end

   // control state with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_PC_W;
         rpc_q    <= RESET_PC_W;
         inf_q    <= 1'b0;
         dsc_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         pc_q     <= pc_d;
         rpc_q    <= rpc_d;
         inf_q    <= inf_d;
         dsc_q    <= dsc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // queue storage register, deliberately without reset
   always_ff @(posedge clk) begin
      dat_q <= dat_d;
      ipc_q <= ipc_d;
   end

endmodule

// File: tb/tb_r5p_fetch.sv
// Bench for r5p_fetch: a queue-based reference model of the instruction
// stream, directed phases from the test plan and a randomized phase.
module tb_r5p_fetch;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam int          DEPTH  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        jmp_vld = 1'b0;
   logic [31:0] jmp_adr = '0;
   logic        ifb_vld;
   logic [31:0] ifb_adr;
   logic        ifb_rdy = 1'b0;
   logic [31:0] ifb_rdt = '0;
   logic        ins_vld;
   logic        ins_rdy = 1'b0;
   logic [31:0] ins_dat;
   logic [31:0] ins_pc;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   r5p_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .jmp_vld (jmp_vld),
      .jmp_adr (jmp_adr),
      .ifb_vld (ifb_vld),
      .ifb_adr (ifb_adr),
      .ifb_rdy (ifb_rdy),
      .ifb_rdt (ifb_rdt),
      .ins_vld (ins_vld),
      .ins_rdy (ins_rdy),
      .ins_dat (ins_dat),
      .ins_pc  (ins_pc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] dat;
   } ent_t;

   // reference model: instructions visible to decode, in order
   ent_t        mq[$];
   logic        m_inf;
   logic [31:0] m_inf_pc;
   logic [31:0] m_pc;

   // values seen at the last sample point
   logic        l_hs;
   logic        l_ivld;
   logic [31:0] l_adr;
   logic [31:0] l_ipc;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_inf    = 1'b0;
      m_inf_pc = '0;
      m_pc     = RST_PC;
   endtask

   // one clock: compare outputs mid-cycle, advance the model at the edge,
   // then act as memory by answering the previous cycle's handshake
   task automatic step();
      logic  e_ivld;
      logic  e_fvld;
      logic  pop;
      ent_t  hd;
      ent_t  ne;
      logic [31:0] rsp_adr;
      @(negedge clk);
      hd     = '0;
      e_ivld = (mq.size() != 0);
      if (e_ivld) hd = mq[0];
      pop    = e_ivld & ins_rdy;
      e_fvld = !rst && !jmp_vld &&
               ((int'(mq.size()) + (m_inf ? 1 : 0) - (pop ? 1 : 0)) < DEPTH);
      chk("ins_vld", 32'(ins_vld), 32'(e_ivld));
      chk("ins_dat", ins_dat, hd.dat);
      chk("ins_pc",  ins_pc,  hd.pc);
      chk("ifb_vld", 32'(ifb_vld), 32'(e_fvld));
      chk("ifb_adr", ifb_adr, m_pc);
      l_hs    = ifb_vld & ifb_rdy;
      l_ivld  = ins_vld;
      l_adr   = ifb_adr;
      l_ipc   = ins_pc;
      rsp_adr = ifb_adr;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else if (jmp_vld) begin
         mq.delete();
         m_inf = 1'b0;
         m_pc  = {jmp_adr[31:2], 2'b00};
      end else begin
         if (pop) void'(mq.pop_front());
         if (m_inf) begin
            ne.pc  = m_inf_pc;
            ne.dat = memf(m_inf_pc);
            mq.push_back(ne);
         end
         if (e_fvld && ifb_rdy) begin
            m_inf    = 1'b1;
            m_inf_pc = m_pc;
            m_pc     = m_pc + 32'd4;
         end else begin
            m_inf = 1'b0;
         end
      end
      cyc++;
      #1;
      ifb_rdt = l_hs ? memf(rsp_adr) : $urandom();
   endtask

   initial begin
      int first;
      int nvld;
      int nreq;
      model_reset();

      // held in reset
      repeat (3) step();
      chk("rst_ifb_adr", ifb_adr, RST_PC);

      // reset fetch, full speed
      ifb_rdy = 1'b1;
      ins_rdy = 1'b1;
      rst     = 1'b0;
      first   = -1;
      nvld    = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (k == 0) chk("cyc0_ifb_vld", 32'(l_hs), 32'd1);
         if (l_ivld) begin
            if (first < 0) first = k;
            nvld++;
         end
      end
      chk("first_vld_cycle", first, 32'd2);
      chk("sustained_vld", nvld, 32'd18);

      // redirect while a response is arriving
      chk("resp_due", 32'(l_hs), 32'd1);
      jmp_vld = 1'b1;
      jmp_adr = 32'h0000_1003;
      step();
      jmp_vld = 1'b0;
      step();
      chk("redir_adr_j1", l_adr, 32'h0000_1000);
      chk("redir_hs_j1", 32'(l_hs), 32'd1);
      step();
      chk("redir_gap_j2", 32'(l_ivld), 32'd0);
      step();
      chk("redir_vld_j3", 32'(l_ivld), 32'd1);
      chk("redir_pc_j3", l_ipc, 32'h0000_1000);
      repeat (5) step();

      // backpressure from an empty queue
      ins_rdy = 1'b0;
      jmp_vld = 1'b1;
      jmp_adr = 32'h0000_2000;
      step();
      jmp_vld = 1'b0;
      nreq    = 0;
      repeat (10) begin
         step();
         if (l_hs) nreq++;
      end
      chk("bp_requests", nreq, DEPTH);
      chk("bp_head_pc", l_ipc, 32'h0000_2000);
      ins_rdy = 1'b1;
      repeat (10) step();

      // randomized bus stalls, decode stalls and redirects
      repeat (1500) begin
         ifb_rdy = ($urandom_range(0, 3) != 0);
         ins_rdy = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 31) == 0) begin
            jmp_vld = 1'b1;
            jmp_adr = $urandom();
         end else begin
            jmp_vld = 1'b0;
         end
         step();
      end
      jmp_vld = 1'b0;

      // reset mid-operation with a response due
      ifb_rdy = 1'b1;
      ins_rdy = 1'b1;
      repeat (4) step();
      chk("pre_rst_ins_vld", 32'(ins_vld), 32'd1);
      chk("pre_rst_resp_due", 32'(l_hs), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_async_ins_vld", 32'(ins_vld), 32'd0);
      chk("rst_async_ins_dat", ins_dat, 32'd0);
      chk("rst_async_ins_pc", ins_pc, 32'd0);
      chk("rst_async_ifb_vld", 32'(ifb_vld), 32'd0);
      chk("rst_async_ifb_adr", ifb_adr, RST_PC);
      model_reset();
      repeat (2) step();
      rst = 1'b0;
      step();
      chk("restart_adr", l_adr, RST_PC);
      repeat (6) step();

      // PC wrap
      jmp_vld = 1'b1;
      jmp_adr = 32'hFFFF_FFFC;
      step();
      jmp_vld = 1'b0;
      step();
      chk("wrap_adr_j1", l_adr, 32'hFFFF_FFFC);
      step();
      chk("wrap_adr_j2", l_adr, 32'h0000_0000);
      step();
      chk("wrap_pc_j3", l_ipc, 32'hFFFF_FFFC);
      step();
      chk("wrap_pc_j4", l_ipc, 32'h0000_0000);
      repeat (4) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
